counter_seq_monitor: RTL

- Downstream consumer of the 4-bit up-counter stage (ripple, synchronous or Johnson).
- Samples the counter's q every clock and predicts the next legal code.
- Declares lock after consecutive correct steps; flags, counts and latches sequence errors.
- Emits a binary step index and a wrap pulse for later display or timing stages.

---
 rtl/counter_pkg.sv | 16 +
 rtl/seq_predict.sv | 74 +++++++
 rtl/counter_seq_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counter sequence monitor:
//   - FSM state encoding used by the top-level monitor
//   - sequence-type selectors for the MODE parameter
package counter_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_TRACK   = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam int MODE_BIN     = 0;
   localparam int MODE_JOHNSON = 1;

endpackage

// File: rtl/seq_predict.sv
// seq_predict
//   Combinational sequence model for the monitored counter.
//   Ports:
//     i_prev   - previously sampled counter code
//     i_q      - currently presented counter code
//     o_next   - legal successor of i_prev
//     o_legal  - i_q is a member of the sequence
//     o_idx    - binary position of i_q in the sequence (0 when illegal)
//     o_is_max - i_prev is the last code before the sequence wraps
//     o_is_min - i_q is the first code of the sequence
module seq_predict
   import counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MODE  = MODE_BIN
) (
   input  logic [WIDTH-1:0] i_prev,
   input  logic [WIDTH-1:0] i_q,
   output logic [WIDTH-1:0] o_next,
   output logic             o_legal,
   output logic [WIDTH-1:0] o_idx,
   output logic             o_is_max,
   output logic             o_is_min
);

   localparam logic [WIDTH-1:0] ZERO        = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] JOHNSON_MAX = {1'b1, {(WIDTH-1){1'b0}}};
   // 2*WIDTH may not fit WIDTH bits (WIDTH=2); modular subtraction still
   // yields the right position because the result is always < 2*WIDTH.
   localparam logic [WIDTH-1:0] TWO_W       = WIDTH'(2 * WIDTH);

   logic [WIDTH-1:0] w_ones;
   logic [WIDTH-1:0] w_edges;
   logic             w_legal;

   // Population count of q and number of adjacent-bit transitions in q.
   // A Johnson code has at most one 0/1 boundary across its bits.
   always_comb begin
      w_ones  = ZERO;
      w_edges = ZERO;
      for (int i = 0; i < WIDTH; i++) begin
         w_ones = w_ones + {{(WIDTH-1){1'b0}}, i_q[i]};
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         w_edges = w_edges + {{(WIDTH-1){1'b0}}, i_q[i] ^ i_q[i+1]};
      end
   end

   // Successor, legality, position and wrap detection per sequence type.
   always_comb begin
      o_is_min = (i_q == ZERO);
      if (MODE == MODE_JOHNSON) begin
         o_next   = {i_prev[WIDTH-2:0], ~i_prev[WIDTH-1]};
         w_legal  = (w_edges <= ONE);
         o_is_max = (i_prev == JOHNSON_MAX);
         if (!w_legal) begin
            o_idx = ZERO;
         end else if (i_q[WIDTH-1] == 1'b0) begin
            o_idx = w_ones;
         end else begin
            o_idx = TWO_W - w_ones;
         end
      end else begin
         o_next   = i_prev + ONE;
         w_legal  = 1'b1;
         o_is_max = (i_prev == ALL_ONES);
         o_idx    = i_q;
      end
      o_legal = w_legal;
   end

endmodule

// File: rtl/counter_seq_monitor.sv
// counter_seq_monitor
//   Watches a counter stage, predicts each next code, declares lock after
//   LOCK_CNT consecutive correct steps and reports sequence errors.
//   Ports:
//     clk        - system clock, rising edge
//     rst        - asynchronous active-low reset
//     q          - counter code under observation
//     sample_en  - 1 = sample q this edge, 0 = hold state
//     clr_err    - synchronous clear of err_sticky / err_count
//     locked     - FSM is in LOCKED
//     err        - one-cycle pulse on a sequence / illegal-code error while locked
//     err_sticky - set by any err, cleared by clr_err or reset
//     err_count  - saturating error total
//     wrap       - one-cycle pulse on a legal max->min step while locked
//     idx        - registered binary position of the last sample
module counter_seq_monitor
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODE     = MODE_BIN,
   parameter int LOCK_CNT = 2,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] q,
   input  logic             sample_en,
   input  logic             clr_err,
   output logic             locked,
   output logic             err,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_count,
   output logic             wrap,
   output logic [WIDTH-1:0] idx
);

   localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);
   localparam logic [ERR_W-1:0] CNT_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] CNT_MAX     = {ERR_W{1'b1}};

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] w_prev_next;
   logic [3:0]       r_match;
   logic [3:0]       w_match_next;
   logic [WIDTH-1:0] r_idx;
   logic [WIDTH-1:0] w_idx_next;
   logic             r_locked;
   logic             r_err;
   logic             w_err_next;
   logic             r_wrap;
   logic             w_wrap_next;
   logic             r_sticky;
   logic [ERR_W-1:0] r_count;

   logic [WIDTH-1:0] w_next;
   logic             w_legal;
   logic [WIDTH-1:0] w_idx;
   logic             w_is_max;
   logic             w_is_min;
   logic             w_hit;

   seq_predict #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
   ) u_predict (
      .i_prev   (r_prev),
      .i_q      (q),
      .o_next   (w_next),
      .o_legal  (w_legal),
      .o_idx    (w_idx),
      .o_is_max (w_is_max),
      .o_is_min (w_is_min)
   );

   assign w_hit = w_legal && (q == w_next);

   // Next-state, match counter and pulse decode for one sample.
   always_comb begin
      w_state_next = r_state;
      w_match_next = r_match;
      w_prev_next  = r_prev;
      w_idx_next   = r_idx;
      w_err_next   = 1'b0;
      w_wrap_next  = 1'b0;
      if (sample_en) begin
         w_prev_next = q;
         w_idx_next  = w_idx;
         case (r_state)
            ST_ACQUIRE: begin
               w_match_next = 4'd0;
               if (w_legal) begin
                  w_state_next = ST_TRACK;
               end else begin
                  w_state_next = ST_ACQUIRE;
               end
            end
            ST_TRACK: begin
               if (!w_legal) begin
                  w_match_next = 4'd0;
                  w_state_next = ST_ACQUIRE;
               end else if (w_hit) begin
                  // r_match < LOCK_CNT <= 15 here, so the increment cannot wrap.
                  w_match_next = r_match + 4'd1;
                  if (w_match_next >= LOCK_TARGET) begin
                     w_state_next = ST_LOCKED;
                  end else begin
                     w_state_next = ST_TRACK;
                  end
               end else begin
                  w_match_next = 4'd0;
                  w_state_next = ST_TRACK;
               end
            end
            ST_LOCKED: begin
               if (w_hit) begin
                  w_wrap_next = w_is_max && w_is_min;
               end else begin
                  w_err_next   = 1'b1;
                  w_match_next = 4'd0;
                  if (w_legal) begin
                     w_state_next = ST_TRACK;
                  end else begin
                     w_state_next = ST_ACQUIRE;
                  end
               end
            end
            default: begin
               w_match_next = 4'd0;
               w_state_next = ST_ACQUIRE;
            end
         endcase
      end else begin
         w_state_next = r_state;
         w_match_next = r_match;
      end
   end

   // Sequence state, sampled code, position and pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_ACQUIRE;
         r_prev   <= {WIDTH{1'b0}};
         r_match  <= 4'd0;
         r_idx    <= {WIDTH{1'b0}};
         r_locked <= 1'b0;
         r_err    <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_prev   <= w_prev_next;
         r_match  <= w_match_next;
         r_idx    <= w_idx_next;
         r_locked <= (w_state_next == ST_LOCKED);
         r_err    <= w_err_next;
         r_wrap   <= w_wrap_next;
      end
   end

   // Error bookkeeping: a new error outranks clr_err so it is never lost.
   // clr_err is an explicit command and acts whether or not q is sampled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sticky <= 1'b0;
         r_count  <= {ERR_W{1'b0}};
      end else if (w_err_next) begin
         r_sticky <= 1'b1;
         if (clr_err) begin
            r_count <= CNT_ONE;
         end else if (r_count == CNT_MAX) begin
            r_count <= CNT_MAX;
         end else begin
            r_count <= r_count + CNT_ONE;
         end
      end else if (clr_err) begin
         r_sticky <= 1'b0;
         r_count  <= {ERR_W{1'b0}};
      end else begin
         r_sticky <= r_sticky;
         r_count  <= r_count;
      end
   end

   assign locked     = r_locked;
   assign err        = r_err;
   assign err_sticky = r_sticky;
   assign err_count  = r_count;
   assign wrap       = r_wrap;
   assign idx        = r_idx;

endmodule
